// File: rtl/fnd_pkg.sv
// Shared constants for the multiplexed 7-segment scan decoder: segment codes,
// digit-enable codes and the frame FSM state encoding.
package fnd_pkg;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a} with dp forced to 1.
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  localparam logic [3:0] COM_D0    = 4'b1110;
  localparam logic [3:0] COM_D1    = 4'b1101;
  localparam logic [3:0] COM_D2    = 4'b1011;
  localparam logic [3:0] COM_D3    = 4'b0111;
  localparam logic [3:0] COM_BLANK = 4'b1111;

  // Encoding doubles as the index of the digit each state is waiting for.
  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_D1   = 2'd1,
    ST_D2   = 2'd2,
    ST_D3   = 2'd3
  } state_t;

  function automatic logic [13:0] bcd_to_bin(input logic [3:0] d3, input logic [3:0] d2,
                                             input logic [3:0] d1, input logic [3:0] d0);
    return 14'(d3) * 14'd1000 + 14'(d2) * 14'd100 + 14'(d1) * 14'd10 + 14'(d0);
  endfunction

endpackage

// File: rtl/fnd_seg_decode.sv
// Maps an active-low segment pattern to its BCD digit; dp is ignored.
module fnd_seg_decode
  import fnd_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case ({1'b1, pattern[6:0]})
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Recovers a 4-digit value from a scanned 7-segment display bus: debounces each
// digit dwell, checks scan order and publishes complete frames.
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  fnd_com,
  input  logic [7:0]  fnd_data,
  output logic [13:0] value,
  output logic [15:0] bcd,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        com_err,
  output state_t      fsm_state
);

  logic [3:0] com_q;
  logic [7:0] data_q;
  logic [7:0] cnt;
  logic       same;
  logic       accept;
  logic       com_legal;
  logic [1:0] com_idx;
  logic [3:0] seg_digit;
  logic       seg_valid;
  logic [3:0] d0, d1, d2;
  logic [2:0] dp_part;
  state_t     state;

  fnd_seg_decode u_seg_decode (
    .pattern (data_q),
    .digit   (seg_digit),
    .valid   (seg_valid)
  );

  // Acceptance fires on the edge that takes the counter to STABLE_CYCLES, so
  // a dwell is taken once no matter how long it lasts.
  assign same   = (fnd_com == com_q) && (fnd_data == data_q);
  assign accept = same && (cnt == 8'(STABLE_CYCLES - 1));

  always_comb begin
    com_legal = 1'b1;
    com_idx   = 2'd0;
    case (com_q)
      COM_D0:  com_idx = 2'd0;
      COM_D1:  com_idx = 2'd1;
      COM_D2:  com_idx = 2'd2;
      COM_D3:  com_idx = 2'd3;
      default: com_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      com_q  <= COM_BLANK;
      data_q <= 8'hFF;
      cnt    <= 8'd0;
    end else begin
      com_q  <= fnd_com;
      data_q <= fnd_data;
      if (!same) cnt <= 8'd1;
      else if (cnt < 8'(STABLE_CYCLES)) cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_SYNC;
      value       <= 14'd0;
      bcd         <= 16'd0;
      dp          <= 4'd0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      com_err     <= 1'b0;
      d0          <= 4'd0;
      d1          <= 4'd0;
      d2          <= 4'd0;
      dp_part     <= 3'd0;
    end else begin
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      com_err     <= 1'b0;
      if (accept && com_q != COM_BLANK) begin
        if (!com_legal) begin
          com_err <= 1'b1;
          state   <= ST_SYNC;
        end else if (!seg_valid) begin
          seg_err <= 1'b1;
          state   <= ST_SYNC;
        end else if (com_idx == 2'(state)) begin
          case (state)
            ST_SYNC: begin d0 <= seg_digit; dp_part[0] <= ~data_q[7]; state <= ST_D1; end
            ST_D1:   begin d1 <= seg_digit; dp_part[1] <= ~data_q[7]; state <= ST_D2; end
            ST_D2:   begin d2 <= seg_digit; dp_part[2] <= ~data_q[7]; state <= ST_D3; end
            ST_D3: begin
              value       <= bcd_to_bin(seg_digit, d2, d1, d0);
              bcd         <= {seg_digit, d2, d1, d0};
              dp          <= {~data_q[7], dp_part};
              frame_valid <= 1'b1;
              state       <= ST_SYNC;
            end
          endcase
        end else if (state != ST_SYNC) begin
          // Out of order mid-frame; a fresh digit0 starts a new frame directly.
          com_err <= 1'b1;
          if (com_idx == 2'd0) begin
            d0         <= seg_digit;
            dp_part[0] <= ~data_q[7];
            state      <= ST_D1;
          end else begin
            state <= ST_SYNC;
          end
        end
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed checks of the scan decoder: framing, debounce, error pulses, reset.
module tb_fnd_scan_decoder;
  import fnd_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;
  logic [13:0] value;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        seg_err;
  logic        com_err;
  state_t      fsm_state;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int seg_cnt = 0;
  int com_cnt = 0;

  fnd_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .fnd_com     (fnd_com),
    .fnd_data    (fnd_data),
    .value       (value),
    .bcd         (bcd),
    .dp          (dp),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .com_err     (com_err),
    .fsm_state   (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses last one full cycle, so sampling on the falling edge counts each once.
  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (seg_err) seg_cnt++;
    if (com_err) com_cnt++;
  end

  // Called at a falling edge; holds the pair across n rising edges.
  task automatic drive(input logic [3:0] c, input logic [7:0] d, input int n);
    fnd_com  = c;
    fnd_data = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    fnd_com  = COM_BLANK;
    fnd_data = 8'hFF;
    repeat (2) @(negedge clk);
    checks++; if (value !== 14'd0) begin errors++; $display("FAIL reset_value got %0d want 0", value); end
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd got %h want 0000", bcd); end
    checks++; if (dp !== 4'b0000) begin errors++; $display("FAIL reset_dp got %b want 0000", dp); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", frame_valid); end
    checks++; if (seg_err !== 1'b0) begin errors++; $display("FAIL reset_seg_err got %b want 0", seg_err); end
    checks++; if (com_err !== 1'b0) begin errors++; $display("FAIL reset_com_err got %b want 0", com_err); end
    checks++; if (fsm_state !== ST_SYNC) begin errors++; $display("FAIL reset_state got %0d want 0", fsm_state); end
    rst = 1'b0;
    drive(COM_BLANK, 8'hFF, 3);
  endtask

  task automatic test_in_order_1234();
    int fv0 = fv_cnt, seg0 = seg_cnt, com0 = com_cnt;
    drive(COM_D0, 8'h99, 8);
    drive(COM_D1, 8'hB0, 8);
    drive(COM_D2, 8'hA4, 8);
    drive(COM_D3, 8'hF9, 8);
    drive(COM_BLANK, 8'hFF, 3);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL n1234_fv_count got %0d want 1", fv_cnt - fv0); end
    checks++; if (value !== 14'd1234) begin errors++; $display("FAIL n1234_value got %0d want 1234", value); end
    checks++; if (bcd !== 16'h1234) begin errors++; $display("FAIL n1234_bcd got %h want 1234", bcd); end
    checks++; if (dp !== 4'b0000) begin errors++; $display("FAIL n1234_dp got %b want 0000", dp); end
    checks++; if (com_cnt - com0 !== 0) begin errors++; $display("FAIL n1234_com_err got %0d want 0", com_cnt - com0); end
    checks++; if (seg_cnt - seg0 !== 0) begin errors++; $display("FAIL n1234_seg_err got %0d want 0", seg_cnt - seg0); end
  endtask

  task automatic test_short_dwell();
    int fv0 = fv_cnt, com0 = com_cnt;
    drive(COM_D0, 8'hF9, 3);
    drive(COM_D0, 8'h92, 4);
    drive(COM_D1, 8'hC0, 4);
    drive(COM_D2, 8'hC0, 4);
    drive(COM_D3, 8'hC0, 4);
    drive(COM_BLANK, 8'hFF, 3);
    checks++; if (com_cnt - com0 !== 0) begin errors++; $display("FAIL short_com_err got %0d want 0", com_cnt - com0); end
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL short_fv_count got %0d want 1", fv_cnt - fv0); end
    checks++; if (value !== 14'd5) begin errors++; $display("FAIL short_value got %0d want 5", value); end
    checks++; if (bcd !== 16'h0005) begin errors++; $display("FAIL short_bcd got %h want 0005", bcd); end
  endtask

  task automatic test_seg_err();
    int fv0 = fv_cnt, seg0 = seg_cnt;
    drive(COM_D0, 8'h92, 5);
    drive(COM_D1, 8'hFF, 5);
    drive(COM_BLANK, 8'hFF, 3);
    checks++; if (seg_cnt - seg0 !== 1) begin errors++; $display("FAIL seg_err_count got %0d want 1", seg_cnt - seg0); end
    checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL seg_fv_count got %0d want 0", fv_cnt - fv0); end
    checks++; if (value !== 14'd5) begin errors++; $display("FAIL seg_value_held got %0d want 5", value); end
    checks++; if (fsm_state !== ST_SYNC) begin errors++; $display("FAIL seg_state got %0d want 0", fsm_state); end
  endtask

  task automatic test_com_err();
    int com0 = com_cnt, seg0 = seg_cnt;
    drive(4'b1100, 8'hC0, 4);
    drive(COM_D0, 8'hC0, 5);
    drive(COM_D2, 8'hC0, 5);
    drive(COM_BLANK, 8'hFF, 3);
    checks++; if (com_cnt - com0 !== 2) begin errors++; $display("FAIL com_err_count got %0d want 2", com_cnt - com0); end
    checks++; if (fsm_state !== ST_SYNC) begin errors++; $display("FAIL com_state got %0d want 0", fsm_state); end
    checks++; if (value !== 14'd5) begin errors++; $display("FAIL com_value_held got %0d want 5", value); end
    checks++; if (seg_cnt - seg0 !== 0) begin errors++; $display("FAIL com_seg_err got %0d want 0", seg_cnt - seg0); end
  endtask

  task automatic test_reset_mid_frame();
    int fv0;
    drive(COM_D0, 8'h90, 5);
    drive(COM_D1, 8'h90, 5);
    drive(COM_D2, 8'h90, 5);
    checks++; if (fsm_state !== ST_D3) begin errors++; $display("FAIL mid_state_before got %0d want 3", fsm_state); end
    rst = 1'b1;
    #1;
    checks++; if (value !== 14'd0) begin errors++; $display("FAIL mid_async_value got %0d want 0", value); end
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL mid_async_bcd got %h want 0000", bcd); end
    checks++; if (dp !== 4'b0000) begin errors++; $display("FAIL mid_async_dp got %b want 0000", dp); end
    checks++; if (fsm_state !== ST_SYNC) begin errors++; $display("FAIL mid_async_state got %0d want 0", fsm_state); end
    @(negedge clk);
    rst = 1'b0;
    fv0 = fv_cnt;
    drive(COM_D3, 8'h90, 5);
    drive(COM_BLANK, 8'hFF, 3);
    checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL mid_partial_fv got %0d want 0", fv_cnt - fv0); end
    fv0 = fv_cnt;
    drive(COM_D0, 8'h90, 5);
    drive(COM_D1, 8'h90, 5);
    drive(COM_D2, 8'h10, 5);
    drive(COM_D3, 8'h90, 5);
    drive(COM_BLANK, 8'hFF, 3);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL n9999_fv_count got %0d want 1", fv_cnt - fv0); end
    checks++; if (value !== 14'd9999) begin errors++; $display("FAIL n9999_value got %0d want 9999", value); end
    checks++; if (bcd !== 16'h9999) begin errors++; $display("FAIL n9999_bcd got %h want 9999", bcd); end
    checks++; if (dp !== 4'b0100) begin errors++; $display("FAIL n9999_dp got %b want 0100", dp); end
  endtask

  task automatic test_blank_between();
    int fv0 = fv_cnt, seg0 = seg_cnt, com0 = com_cnt;
    drive(COM_D0, 8'hA4, 5);
    drive(COM_BLANK, 8'hFF, 5);
    drive(COM_D1, 8'h99, 5);
    drive(COM_BLANK, 8'hFF, 5);
    drive(COM_D2, 8'hC0, 5);
    drive(COM_BLANK, 8'hFF, 5);
    drive(COM_D3, 8'hC0, 5);
    drive(COM_BLANK, 8'hFF, 5);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL n0042_fv_count got %0d want 1", fv_cnt - fv0); end
    checks++; if (value !== 14'd42) begin errors++; $display("FAIL n0042_value got %0d want 42", value); end
    checks++; if (bcd !== 16'h0042) begin errors++; $display("FAIL n0042_bcd got %h want 0042", bcd); end
    checks++; if (dp !== 4'b0000) begin errors++; $display("FAIL n0042_dp got %b want 0000", dp); end
    checks++; if ((seg_cnt - seg0) + (com_cnt - com0) !== 0) begin
      errors++; $display("FAIL n0042_errors got %0d want 0", (seg_cnt - seg0) + (com_cnt - com0));
    end
  endtask

  initial begin
    rst      = 1'b1;
    fnd_com  = COM_BLANK;
    fnd_data = 8'hFF;
    @(negedge clk);
    test_reset();
    test_in_order_1234();
    test_short_dwell();
    test_seg_err();
    test_com_err();
    test_reset_mid_frame();
    test_blank_between();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
